trdb_timer_packetizer: RTL and testbench
========================================

Name: trdb_timer_packetizer

Overview:
Responder end of the timer-unit request/grant handshake. Accepts a pending timestamp request from trdb_timer, grants it, and latches the current trdb_time value. It formats the timestamp into a timer trace packet and streams the packet as BUS_WIDTH-bit beats over a valid/ready interface into the packet FIFO/arbiter.

Parameters:
TIMER_WIDTH, 40, width of the timestamp input; legal range 1..114.
BUS_WIDTH, 32, output beat width.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; asynchronous, active-high
enable_i  in  1  trace enabled; when low, granted requests are discarded
flush_i  in  1  synchronous abort of any in-flight packet
tu_valid_i  in  1  timer request pending (held until granted)
tu_grant_o  out  1  one-cycle grant pulse
trdb_time_i  in  TIMER_WIDTH  free-running timestamp
packet_o  out  BUS_WIDTH  packet beat data
packet_valid_o  out  1  beat valid
packet_last_o  out  1  final beat of packet
packet_ready_i  in  1  downstream accepts beat
dropped_o  out  1  one-cycle pulse: granted request discarded (enable_i low)

Behaviour:
- Reset values: all outputs 0; state IDLE; time holding register 0; beat counter 0.
- Packet layout, LSB first:
  - [6:0] length = TIMER_WIDTH+6, i.e. the number of bits following this field.
  - [8:7] format = 2'b11.
  - [12:9] msgtype = MSGT_TIMER (4'h3).
  - [13+TIMER_WIDTH-1:13] timestamp.
  - Total PKT_BITS = TIMER_WIDTH+13. NBEATS = ceil(PKT_BITS/BUS_WIDTH). Bits above PKT_BITS in the last beat are 0.
- States:
  - IDLE:
    - tu_grant_o = tu_valid_i & ~flush_i (combinational).
    - On grant: latch trdb_time_i from the same cycle and clear the beat counter.
    - Next state: SEND if enable_i, otherwise stay IDLE and pulse dropped_o for that cycle.
  - SEND:
    - packet_valid_o = 1. packet_o = beat[counter]. packet_last_o = (counter == NBEATS-1).
    - Beat and counter are held stable while packet_ready_i is low. The counter increments on each handshake.
    - Handshake on the last beat returns to IDLE.
- No grant in SEND. tu_valid_i stays high and is granted on the first IDLE cycle, so there is at least one idle cycle between packets. Latency from grant to the first beat is 1 cycle.
- flush_i:
  - In SEND: return to IDLE next cycle, no further beats. A beat accepted in the same cycle still counts as transferred, but no more beats follow.
  - In IDLE: suppresses the grant, and the request stays pending.
- enable_i is sampled only at grant. Deasserting it mid-packet does not truncate the packet.
- Timestamp wrap-around is transparent: the latched value is emitted verbatim, with no saturation.
- Asynchronous reset mid-packet: outputs drop to 0 immediately; the partial packet is abandoned.

Decomposition:
- trdb_pkg gains:
  - MSGT_TIMER = 4'h3
  - the format constant 2'b11
  - a packed typedef trdb_timer_pkt_t for the header+timestamp layout
  - localparam-style helper constants PKT_BITS and NBEATS
- No sub-module. The beat mux is an indexed slice of the zero-padded packet vector.

Test Plan:
1. Reset, then tu_valid_i=1 with trdb_time_i=40'h1 and ready=1 -> tu_grant_o pulses 1 cycle. Beats are 32'h000027AE, then 32'h00000000 with last=1.
2. trdb_time_i=40'hFF_FFFF_FFFF -> beats 32'hFFFFE7AE, then 32'h001FFFFF with last=1.
3. Backpressure: hold ready=0 for 5 cycles on beat 0 -> packet_o and valid stay stable. A second tu_valid_i during SEND is not granted until the first IDLE cycle after last-beat acceptance.
4. enable_i=0 with tu_valid_i=1 -> grant pulse and dropped_o pulse in the same cycle; packet_valid_o stays 0.
5. flush_i asserted during beat 0 with ready=0 -> valid drops next cycle; no beat 1. Flush together with tu_valid_i in IDLE -> no grant until flush deasserts.
6. rst_i asserted asynchronously mid-packet -> all outputs 0 without waiting for a clock edge. After release, a new request yields a complete, correct packet.

Source files
------------

// File: rtl/trdb_pkg.sv
// rtl/trdb_pkg.sv - shared trace debugger constants and timer packet layout
package trdb_pkg;

  localparam logic [3:0]  MSGT_TIMER        = 4'h3;
  localparam logic [1:0]  TRDB_FORMAT_TIMER = 2'b11;
  localparam int unsigned TIMER_HDR_BITS    = 13;
  localparam int unsigned MAX_TIMER_WIDTH   = 114;

  // Timestamp sits above the header; narrower timers are zero-extended into it.
  typedef struct packed {
    logic [MAX_TIMER_WIDTH-1:0] timestamp;
    logic [3:0]                 msgtype;
    logic [1:0]                 format;
    logic [6:0]                 length;
  } trdb_timer_pkt_t;

  function automatic int unsigned timer_pkt_bits(int unsigned timer_width);
    return timer_width + TIMER_HDR_BITS;
  endfunction

  function automatic int unsigned timer_pkt_nbeats(int unsigned timer_width,
                                                   int unsigned bus_width);
    return (timer_pkt_bits(timer_width) + bus_width - 1) / bus_width;
  endfunction

endpackage

// File: rtl/trdb_timer_packetizer.sv
// rtl/trdb_timer_packetizer.sv - grants timer requests and streams timer trace packets
module trdb_timer_packetizer
  import trdb_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH = 40,
  parameter int unsigned BUS_WIDTH   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   flush_i,
  input  logic                   tu_valid_i,
  output logic                   tu_grant_o,
  input  logic [TIMER_WIDTH-1:0] trdb_time_i,
  output logic [BUS_WIDTH-1:0]   packet_o,
  output logic                   packet_valid_o,
  output logic                   packet_last_o,
  input  logic                   packet_ready_i,
  output logic                   dropped_o
);

  localparam int unsigned PKT_BITS = timer_pkt_bits(TIMER_WIDTH);
  localparam int unsigned NBEATS   = timer_pkt_nbeats(TIMER_WIDTH, BUS_WIDTH);
  localparam int unsigned PAD_BITS = NBEATS * BUS_WIDTH;
  localparam int unsigned CNT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e                           state_q;
  logic [TIMER_WIDTH-1:0]           time_q;
  logic [CNT_W-1:0]                 cnt_q;
  trdb_timer_pkt_t                  pkt;
  logic [NBEATS-1:0][BUS_WIDTH-1:0] beats;
  logic                             grant;
  logic                             is_last;

  always_comb begin
    pkt           = '0;
    pkt.length    = 7'(TIMER_WIDTH + 6);
    pkt.format    = TRDB_FORMAT_TIMER;
    pkt.msgtype   = MSGT_TIMER;
    pkt.timestamp = MAX_TIMER_WIDTH'(time_q);
  end

  // Casting to the beat-aligned width pads or trims above PKT_BITS with zeros.
  assign beats   = PAD_BITS'(pkt);
  assign is_last = (cnt_q == CNT_W'(NBEATS - 1));

  assign grant          = (state_q == IDLE) & tu_valid_i & ~flush_i & ~rst_i;
  assign tu_grant_o     = grant;
  assign dropped_o      = grant & ~enable_i;
  assign packet_valid_o = (state_q == SEND);
  assign packet_last_o  = packet_valid_o & is_last;
  assign packet_o       = packet_valid_o ? beats[cnt_q] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      time_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            time_q <= trdb_time_i;
            cnt_q  <= '0;
            if (enable_i) state_q <= SEND;
          end
        end
        SEND: begin
          // A beat accepted alongside flush still counts; nothing follows it.
          if (flush_i) begin
            state_q <= IDLE;
          end else if (packet_ready_i) begin
            if (is_last) state_q <= IDLE;
            else         cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trdb_timer_packetizer.sv
// tb/tb_trdb_timer_packetizer.sv - self-checking bench for trdb_timer_packetizer
module tb_trdb_timer_packetizer;

  localparam int TW = 40;
  localparam int BW = 32;
  localparam int NB = (TW + 13 + BW - 1) / BW;

  logic          clk_i = 0;
  logic          rst_i;
  logic          enable_i;
  logic          flush_i;
  logic          tu_valid_i;
  logic          tu_grant_o;
  logic [TW-1:0] trdb_time_i;
  logic [BW-1:0] packet_o;
  logic          packet_valid_o;
  logic          packet_last_o;
  logic          packet_ready_i;
  logic          dropped_o;

  int checks   = 0;
  int failures = 0;
  logic [BW-1:0] got [NB];

  trdb_timer_packetizer #(.TIMER_WIDTH(TW), .BUS_WIDTH(BW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .flush_i        (flush_i),
    .tu_valid_i     (tu_valid_i),
    .tu_grant_o     (tu_grant_o),
    .trdb_time_i    (trdb_time_i),
    .packet_o       (packet_o),
    .packet_valid_o (packet_valid_o),
    .packet_last_o  (packet_last_o),
    .packet_ready_i (packet_ready_i),
    .dropped_o      (dropped_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: build the whole packet as a number, then cut it into beats.
  function automatic logic [BW-1:0] exp_beat(logic [TW-1:0] ts, int b);
    logic [255:0] p;
    p = 256'(ts) << 13;
    p = p | (256'(4'h3) << 9) | (256'(2'b11) << 7) | 256'(TW + 6);
    return p[b*BW +: BW];
  endfunction

  function automatic logic [TW-1:0] rand_ts();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[TW-1:0];
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_valid"}, 64'(packet_valid_o), 64'd0);
    check({tag, "_last"},  64'(packet_last_o),  64'd0);
    check({tag, "_data"},  64'(packet_o),       64'd0);
  endtask

  // Receives all beats of the packet for ts, starting on the cycle after grant.
  task automatic recv(logic [TW-1:0] ts, int stall_max, bit drop_en);
    if (drop_en) enable_i = 0;
    for (int b = 0; b < NB; b++) begin
      int n;
      n = $urandom_range(0, stall_max);
      packet_ready_i = 0;
      for (int k = 0; k < n; k++) begin
        #1;
        check("stall_valid", 64'(packet_valid_o), 64'd1);
        check("stall_data",  64'(packet_o), 64'(exp_beat(ts, b)));
        tick();
      end
      packet_ready_i = 1;
      #1;
      check("beat_valid", 64'(packet_valid_o), 64'd1);
      check("beat_data",  64'(packet_o), 64'(exp_beat(ts, b)));
      check("beat_last",  64'(packet_last_o), 64'(b == NB - 1));
      check("send_no_grant", 64'(tu_grant_o), 64'd0);
      got[b] = packet_o;
      tick();
    end
    packet_ready_i = 0;
    enable_i = 1;
    #1;
    check("post_valid", 64'(packet_valid_o), 64'd0);
    tick();
  endtask

  task automatic do_packet(logic [TW-1:0] ts, int stall_max, bit drop_en);
    tu_valid_i  = 1;
    trdb_time_i = ts;
    #1;
    check("grant", 64'(tu_grant_o), 64'd1);
    check("grant_no_drop", 64'(dropped_o), 64'd0);
    tick();
    tu_valid_i  = 0;
    trdb_time_i = rand_ts();
    recv(ts, stall_max, drop_en);
  endtask

  initial begin
    logic [TW-1:0] ts_a, ts_b;
    rst_i = 1; enable_i = 1; flush_i = 0; tu_valid_i = 0;
    trdb_time_i = '0; packet_ready_i = 0;
    #3;
    check_quiet("reset");
    check("reset_grant", 64'(tu_grant_o), 64'd0);
    check("reset_drop",  64'(dropped_o),  64'd0);
    tick(); tick();
    rst_i = 0;
    tick();

    // Known-answer packets, including an all-ones timestamp
    do_packet(40'h1, 0, 0);
    check("kat1_b0", 64'(got[0]), 64'h000027AE);
    check("kat1_b1", 64'(got[1]), 64'h00000000);
    do_packet(40'hFF_FFFF_FFFF, 0, 0);
    check("kat2_b0", 64'(got[0]), 64'hFFFFE7AE);
    check("kat2_b1", 64'(got[1]), 64'h001FFFFF);

    // Backpressure on beat 0 while a second request waits
    ts_a = rand_ts(); ts_b = rand_ts();
    tu_valid_i = 1; trdb_time_i = ts_a; packet_ready_i = 0;
    #1;
    check("bp_grant", 64'(tu_grant_o), 64'd1);
    tick();
    trdb_time_i = ts_b;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_valid", 64'(packet_valid_o), 64'd1);
      check("bp_data",  64'(packet_o), 64'(exp_beat(ts_a, 0)));
      check("bp_no_grant", 64'(tu_grant_o), 64'd0);
      tick();
    end
    packet_ready_i = 1;
    for (int b = 0; b < NB; b++) begin
      #1;
      check("bp_beat", 64'(packet_o), 64'(exp_beat(ts_a, b)));
      check("bp_last", 64'(packet_last_o), 64'(b == NB - 1));
      check("bp_hold_grant", 64'(tu_grant_o), 64'd0);
      tick();
    end
    packet_ready_i = 0;
    #1;
    check("bp_idle_valid", 64'(packet_valid_o), 64'd0);
    check("bp_second_grant", 64'(tu_grant_o), 64'd1);
    tick();
    tu_valid_i = 0;
    recv(ts_b, 2, 0);

    // Disabled trace: grant and drop together, no packet
    enable_i = 0; tu_valid_i = 1; trdb_time_i = rand_ts(); packet_ready_i = 1;
    #1;
    check("dis_grant", 64'(tu_grant_o), 64'd1);
    check("dis_drop",  64'(dropped_o),  64'd1);
    tick();
    tu_valid_i = 0; enable_i = 1;
    #1;
    check("dis_drop_pulse", 64'(dropped_o), 64'd0);
    check_quiet("dis_after");
    tick();
    #1;
    check_quiet("dis_after2");
    tick();
    packet_ready_i = 0;

    // Flush during beat 0 under backpressure
    ts_a = rand_ts();
    tu_valid_i = 1; trdb_time_i = ts_a;
    #1;
    check("fl_grant", 64'(tu_grant_o), 64'd1);
    tick();
    tu_valid_i = 0; flush_i = 1;
    #1;
    check("fl_valid_same", 64'(packet_valid_o), 64'd1);
    tick();
    flush_i = 0;
    #1;
    check_quiet("fl_after");
    tick();
    #1;
    check_quiet("fl_after2");
    tick();

    // Flush in idle holds off a pending request
    flush_i = 1; tu_valid_i = 1; ts_a = rand_ts(); trdb_time_i = ts_a;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("fl_idle_grant", 64'(tu_grant_o), 64'd0);
      check("fl_idle_valid", 64'(packet_valid_o), 64'd0);
      tick();
    end
    flush_i = 0;
    do_packet(ts_a, 1, 0);

    // Asynchronous reset mid-packet, then recovery
    ts_a = rand_ts();
    tu_valid_i = 1; trdb_time_i = ts_a;
    #1;
    check("ar_grant", 64'(tu_grant_o), 64'd1);
    tick();
    tu_valid_i = 0;
    #1;
    check("ar_valid_pre", 64'(packet_valid_o), 64'd1);
    #1;
    rst_i = 1;
    #1;
    check_quiet("ar_async");
    check("ar_grant_low", 64'(tu_grant_o), 64'd0);
    tick();
    rst_i = 0;
    tick();
    do_packet(rand_ts(), 0, 0);

    // Randomized packets, stalls and mid-packet enable drops
    for (int i = 0; i < 20; i++) begin
      do_packet(rand_ts(), 3, bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
